dice_score_engine: RTL

Dice roll and scoring stage that sits directly upstream of the game FSM. On each roll request it draws new values for the un-held dice from a free-running LFSR. It then builds a face histogram over several cycles and returns the score of the currently selected category. The game FSM consumes `calc_score` as its current score input, and this block consumes the FSM's `roll_trigger` and `category_idx`.

---
 rtl/dice_score_engine_if.sv | 34 +++
 rtl/dice_score_engine.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dice_score_engine_if.sv
// Roll/score bus between the game FSM (master) and dice_score_engine (slave).
// The force_en/force_dice signals exist only when DICE_FORCE_EN is defined.
interface dice_score_engine_if;
  logic        roll_trigger;
  logic [4:0]  hold_mask;
  logic [3:0]  category_idx;
  logic [14:0] dice_out;
  logic        dice_valid;
  logic [7:0]  calc_score;
  logic        score_valid;
  logic        busy;
`ifdef DICE_FORCE_EN
  logic        force_en;
  logic [14:0] force_dice;

  modport master (
    output roll_trigger, hold_mask, category_idx, force_en, force_dice,
    input  dice_out, dice_valid, calc_score, score_valid, busy
  );
  modport slave (
    input  roll_trigger, hold_mask, category_idx, force_en, force_dice,
    output dice_out, dice_valid, calc_score, score_valid, busy
  );
`else
  modport master (
    output roll_trigger, hold_mask, category_idx,
    input  dice_out, dice_valid, calc_score, score_valid, busy
  );
  modport slave (
    input  roll_trigger, hold_mask, category_idx,
    output dice_out, dice_valid, calc_score, score_valid, busy
  );
`endif
endinterface

// File: rtl/dice_score_engine.sv
// Dice roll and scoring stage: LFSR draws, per-die histogram, category scoring.
// Optional DICE_FORCE_EN adds deterministic forced dice values at roll acceptance.
module dice_score_engine #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  dice_score_engine_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ROLL  = 3'd1;
  localparam logic [2:0] ST_COUNT = 3'd2;
  localparam logic [2:0] ST_EVAL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]       state_r;
  logic [2:0]       die_idx_r;
  logic [4:0]       mask_r;
  logic [15:0]      lfsr_r;
  logic [14:0]      dice_r;
  logic [5:0][2:0]  cnt_r;
  logic [4:0]       sum_r;
  logic [7:0]       score_r;
  logic [3:0]       last_cat_r;
  logic             rescore_r;
  logic             dice_valid_r;
  logic             score_valid_r;
  logic             busy_r;
`ifdef DICE_FORCE_EN
  logic             force_en_r;
  logic [14:0]      force_dice_r;
`endif

  logic [3:0]       idx_base_s;
  logic [2:0]       cur_die_s;
  logic             draw_en_s;
  logic [2:0]       draw_s;
  logic [7:0]       score_s;
  logic [5:0]       present_s;
  logic             any4_s;
  logic             any5_s;
  logic             has3_s;
  logic             has2_s;
  logic             roll_accept_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Scale an 8-bit random byte onto 1..6 without a divider.
  function automatic logic [2:0] lfsr_die(input logic [7:0] v);
    logic [10:0] prod;
    prod = {3'b000, v} * 11'd6;
    return prod[10:8] + 3'd1;
  endfunction

  function automatic logic [2:0] clamp_face(input logic [2:0] v);
    logic [2:0] r;
    case (v)
      3'd0:    r = 3'd1;
      3'd7:    r = 3'd6;
      default: r = v;
    endcase
    return r;
  endfunction

  // Current die selection and the value a roll would give it.
  always_comb begin
    idx_base_s = {die_idx_r, 1'b0} + {1'b0, die_idx_r};
    cur_die_s  = dice_r[idx_base_s +: 3];
    draw_en_s  = (mask_r[die_idx_r] == 1'b0) || (cur_die_s == 3'd0);
`ifdef DICE_FORCE_EN
    if (force_en_r) begin
      draw_s = clamp_face(force_dice_r[idx_base_s +: 3]);
    end else begin
      draw_s = lfsr_die(lfsr_r[7:0]);
    end
`else
    draw_s = lfsr_die(lfsr_r[7:0]);
`endif
  end

  // Histogram features and the score of the selected category.
  always_comb begin
    present_s = 6'd0;
    any4_s    = 1'b0;
    any5_s    = 1'b0;
    has3_s    = 1'b0;
    has2_s    = 1'b0;
    for (int f = 0; f < 6; f++) begin
      present_s[f] = (cnt_r[f] != 3'd0);
      any4_s = any4_s | (cnt_r[f] >= 3'd4);
      any5_s = any5_s | (cnt_r[f] == 3'd5);
      has3_s = has3_s | (cnt_r[f] == 3'd3);
      has2_s = has2_s | (cnt_r[f] == 3'd2);
    end
    score_s = 8'd0;
    case (bus.category_idx)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5:
        score_s = {5'd0, bus.category_idx[2:0] + 3'd1} * {5'd0, cnt_r[bus.category_idx[2:0]]};
      4'd6:
        score_s = {3'd0, sum_r};
      4'd7:
        score_s = any4_s ? {3'd0, sum_r} : 8'd0;
      4'd8:
        score_s = (has3_s && has2_s) ? {3'd0, sum_r} : 8'd0;
      4'd9:
        score_s = ((present_s[3:0] == 4'hF) || (present_s[4:1] == 4'hF) ||
                   (present_s[5:2] == 4'hF)) ? 8'd15 : 8'd0;
      4'd10:
        score_s = ((present_s[4:0] == 5'h1F) || (present_s[5:1] == 5'h1F)) ? 8'd30 : 8'd0;
      4'd11:
        score_s = any5_s ? 8'd50 : 8'd0;
      default:
        score_s = 8'd0;
    endcase
  end

  assign roll_accept_s = bus.roll_trigger && ((state_r == ST_IDLE) || (state_r == ST_DONE));

  // LFSR, roll/count/eval sequencing and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      die_idx_r     <= 3'd0;
      mask_r        <= 5'd0;
      lfsr_r        <= SEED;
      dice_r        <= 15'd0;
      cnt_r         <= '0;
      sum_r         <= 5'd0;
      score_r       <= 8'd0;
      last_cat_r    <= 4'd0;
      rescore_r     <= 1'b0;
      dice_valid_r  <= 1'b0;
      score_valid_r <= 1'b0;
      busy_r        <= 1'b0;
`ifdef DICE_FORCE_EN
      force_en_r    <= 1'b0;
      force_dice_r  <= 15'd0;
`endif
    end else begin
      lfsr_r <= lfsr_step(lfsr_r);
      if (roll_accept_s) begin
        state_r       <= ST_ROLL;
        die_idx_r     <= 3'd0;
        mask_r        <= bus.hold_mask;
        rescore_r     <= 1'b0;
        dice_valid_r  <= 1'b0;
        score_valid_r <= 1'b0;
        busy_r        <= 1'b1;
`ifdef DICE_FORCE_EN
        force_en_r    <= bus.force_en;
        force_dice_r  <= bus.force_dice;
`endif
      end else begin
        case (state_r)
          ST_ROLL: begin
            if (draw_en_s) begin
              dice_r[idx_base_s +: 3] <= draw_s;
            end
            if (die_idx_r == 3'd4) begin
              state_r   <= ST_COUNT;
              die_idx_r <= 3'd0;
              cnt_r     <= '0;
              sum_r     <= 5'd0;
            end else begin
              die_idx_r <= die_idx_r + 3'd1;
            end
          end
          ST_COUNT: begin
            cnt_r[cur_die_s - 3'd1] <= cnt_r[cur_die_s - 3'd1] + 3'd1;
            sum_r <= sum_r + {2'b00, cur_die_s};
            if (die_idx_r == 3'd4) begin
              state_r   <= ST_EVAL;
              die_idx_r <= 3'd0;
            end else begin
              die_idx_r <= die_idx_r + 3'd1;
            end
          end
          ST_EVAL: begin
            score_r       <= score_s;
            last_cat_r    <= bus.category_idx;
            dice_valid_r  <= 1'b1;
            busy_r        <= 1'b0;
            // A re-score is only confirmed in DONE, once the category has held still.
            score_valid_r <= ~rescore_r;
            rescore_r     <= 1'b0;
            state_r       <= ST_DONE;
          end
          ST_DONE: begin
            if (bus.category_idx != last_cat_r) begin
              state_r       <= ST_EVAL;
              score_valid_r <= 1'b0;
              rescore_r     <= 1'b1;
              busy_r        <= 1'b1;
            end else begin
              score_valid_r <= 1'b1;
            end
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dice_out    = dice_r;
  assign bus.dice_valid  = dice_valid_r;
  assign bus.calc_score  = score_r;
  assign bus.score_valid = score_valid_r;
  assign bus.busy        = busy_r;

endmodule
